// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
//   Control unit for the 5-stage SIMPLE pipeline (P1 fetch .. P5 writeback).
//   Owns run/stop, the fetch PC and the P3..P5 valid bits. It stalls P1/P2
//   behind a bubble on read-after-write hazards, redirects fetch on branches
//   resolved in P3 (squashing P1/P2), and drains the pipe on HLT or stop.
//
//   Optional feature macro: PIPE_FWD_EN
//     defined   - operand forwarding from P4 DR / P5 writeback; only a load
//                 in P3 feeding a reader in P2 stalls (one bubble)
//     undefined - fwd_a/fwd_b tied to 0; any valid writer in P3 or P4 whose
//                 destination is read by P2 stalls the front end
//
// Parameters
//   PC_W      PC / branch-target width
//   START_PC  PC loaded on reset
//
// Ports
//   clock      in   system clock, all state on posedge
//   reset      in   asynchronous, active-high
//   exec       in   board level; each rising edge toggles run/stop
//   p2_ir      in   instruction in P2 (register read)
//   p3_ir      in   instruction in P3 (ALU / branch resolve)
//   p4_ir      in   instruction in P4 (memory)
//   br_taken   in   P3 conditional-branch condition
//   br_target  in   P3 branch target
//   pc         out  fetch address
//   hold_p12   out  P1/P2 registers keep their value
//   bubble_p3  out  P3 loads a NOP
//   valid_p3   out  P3 holds a real instruction
//   valid_p4   out  P4 holds a real instruction
//   valid_p5   out  P5 holds a real instruction (gates RegWrite/store)
//   running    out  sequencer in RUN
//   fwd_a      out  source of P3 operand A (the rb field): 0 reg, 1 P4 DR, 2 P5 WB
//   fwd_b      out  source of P3 operand B (the ra field), same encoding

module pipeline_sequencer #(
  parameter int              PC_W     = 12,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            exec,
  input  logic [15:0]     p2_ir,
  input  logic [15:0]     p3_ir,
  input  logic [15:0]     p4_ir,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] pc,
  output logic            hold_p12,
  output logic            bubble_p3,
  output logic            valid_p3,
  output logic            valid_p4,
  output logic            valid_p5,
  output logic            running,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
);

  typedef enum logic [1:0] {STOP, RUN, DRAIN} state_t;

  state_t state, state_next;

  logic exec_q;
  logic idle_q;
  logic squash_q;
  logic exec_rise;
  logic take_branch;
  logic hlt_p3;
  logic hazard;
  logic stall;
  logic [3:0] dest_p4;
  logic unused_bits;

  // {writes, register} for an instruction, given ir[15:4]
  function automatic logic [3:0] dest_of(input logic [11:0] hi);
    logic [3:0] d;
    d = 4'b0000;
    case (hi[11:10])
      2'b11: if (!(hi[3:0] inside {4'b0101, 4'b1101, 4'b1111})) d = {1'b1, hi[6:4]};
      2'b00: d = {1'b1, hi[9:7]};
      2'b10: if (hi[9:7] == 3'b000) d = {1'b1, hi[6:4]};
      default: d = 4'b0000;
    endcase
    return d;
  endfunction

  function automatic logic reads_ra(input logic [1:0] op1);
    return (op1 == 2'b11) || (op1 == 2'b01);
  endfunction

  function automatic logic reads_rb(input logic [1:0] op1);
    return op1 != 2'b10;
  endfunction

  // Does the instruction (ir[15:8]) read the register named by d?
  function automatic logic uses_reg(input logic [7:0] hi, input logic [3:0] d);
    return d[3] && ((reads_ra(hi[7:6]) && hi[5:3] == d[2:0]) ||
                    (reads_rb(hi[7:6]) && hi[2:0] == d[2:0]));
  endfunction

  // Only the opcode/register fields matter here; the low bits are data.
  assign unused_bits = ^{p2_ir, p3_ir, p4_ir};

  assign exec_rise   = exec && !exec_q;
  assign hlt_p3      = valid_p3 && p3_ir[15:14] == 2'b11 && p3_ir[7:4] == 4'b1111;
  assign take_branch = valid_p3 && p3_ir[15:14] == 2'b10 &&
                       (p3_ir[13:11] == 3'b100 || (p3_ir[13:11] == 3'b111 && br_taken));
  assign dest_p4     = valid_p4 ? dest_of(p4_ir[15:4]) : 4'b0000;

`ifdef PIPE_FWD_EN
  logic [3:0] dest_p5;

  // A load's data only exists after P4, so it alone must stall one slot.
  assign hazard = valid_p3 && p3_ir[15:14] == 2'b00 &&
                  uses_reg(p2_ir[15:8], {1'b1, p3_ir[13:11]});

  // Destination of the instruction now in writeback, tracked from P4.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) dest_p5 <= 4'b0000;
    else       dest_p5 <= dest_p4;
  end

  // P4 holds the newer value, so it wins over P5.
  always_comb begin
    fwd_a = 2'd0;
    fwd_b = 2'd0;
    if (valid_p3 && reads_rb(p3_ir[15:14])) begin
      if (dest_p4 == {1'b1, p3_ir[10:8]})      fwd_a = 2'd1;
      else if (dest_p5 == {1'b1, p3_ir[10:8]}) fwd_a = 2'd2;
    end
    if (valid_p3 && reads_ra(p3_ir[15:14])) begin
      if (dest_p4 == {1'b1, p3_ir[13:11]})      fwd_b = 2'd1;
      else if (dest_p5 == {1'b1, p3_ir[13:11]}) fwd_b = 2'd2;
    end
  end
`else
  logic [3:0] dest_p3;

  // Without forwarding, P2 waits until the producer reaches P5; the
  // register file writes on negedge so P5 itself needs no wait.
  assign dest_p3 = valid_p3 ? dest_of(p3_ir[15:4]) : 4'b0000;
  assign hazard  = uses_reg(p2_ir[15:8], dest_p3) || uses_reg(p2_ir[15:8], dest_p4);
  assign fwd_a   = 2'd0;
  assign fwd_b   = 2'd0;
`endif

  // A taken branch outranks a stall, and the slot after it holds a dead
  // instruction in P2 that must not hold the front end either.
  assign stall = (state == RUN) && hazard && !take_branch && !squash_q;

  // Next state plus the combinational front-end controls.
  always_comb begin
    state_next = state;
    running    = (state == RUN);
    hold_p12   = idle_q || stall;
    bubble_p3  = idle_q || stall;
    case (state)
      STOP:    if (exec_rise) state_next = RUN;
      RUN:     if (exec_rise || hlt_p3) state_next = DRAIN;
      DRAIN:   if (!valid_p4 && !valid_p5) state_next = STOP;
      default: state_next = STOP;
    endcase
  end

  // State, PC and valid pipe. idle_q mirrors "not in RUN" one cycle ahead so
  // hold/bubble read 0 while in reset and 1 from the first STOP cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= STOP;
      exec_q   <= 1'b0;
      idle_q   <= 1'b0;
      squash_q <= 1'b0;
      pc       <= START_PC;
      valid_p3 <= 1'b0;
      valid_p4 <= 1'b0;
      valid_p5 <= 1'b0;
    end else begin
      state    <= state_next;
      exec_q   <= exec;
      idle_q   <= (state_next != RUN);
      squash_q <= take_branch;
      if (take_branch)
        pc <= br_target;
      else if (state == RUN && !stall)
        pc <= pc + {{(PC_W-1){1'b0}}, 1'b1};
      valid_p3 <= (state == RUN) && !stall && !take_branch && !squash_q;
      valid_p4 <= valid_p3;
      valid_p5 <= valid_p4;
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer
//   Directed bench for pipeline_sequencer: drives the P2/P3/P4 instruction
//   words cycle by cycle and compares outputs with hand-computed values.

module tb_pipeline_sequencer;

  localparam logic [15:0] NOP  = 16'h8800;  // reads and writes nothing
  localparam logic [15:0] ADD  = 16'hD100;  // ADD r1,r2 : writes r1 (rb)
  localparam logic [15:0] SUB  = 16'hCB10;  // SUB r3,r1 : reads r1 via ra
  localparam logic [15:0] LD   = 16'h0A00;  // LD r1,(r2): writes r1 (ra)
  localparam logic [15:0] BR   = 16'hA000;  // B  (always taken)
  localparam logic [15:0] BCC  = 16'hB800;  // conditional branch
  localparam logic [15:0] HLT  = 16'hC0F0;

  logic        clock;
  logic        reset;
  logic        exec;
  logic [15:0] p2_ir, p3_ir, p4_ir;
  logic        br_taken;
  logic [11:0] br_target;
  logic [11:0] pc;
  logic        hold_p12, bubble_p3, valid_p3, valid_p4, valid_p5, running;
  logic [1:0]  fwd_a, fwd_b;

  int          checkCount;
  int          passCount;
  logic [11:0] exp_pc;

  pipeline_sequencer dut (
    .clock(clock), .reset(reset), .exec(exec),
    .p2_ir(p2_ir), .p3_ir(p3_ir), .p4_ir(p4_ir),
    .br_taken(br_taken), .br_target(br_target),
    .pc(pc), .hold_p12(hold_p12), .bubble_p3(bubble_p3),
    .valid_p3(valid_p3), .valid_p4(valid_p4), .valid_p5(valid_p5),
    .running(running), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [15:0] i2, input logic [15:0] i3,
                               input logic [15:0] i4, input logic ex,
                               input logic bt, input logic [11:0] tgt);
    p2_ir = i2; p3_ir = i3; p4_ir = i4;
    exec = ex; br_taken = bt; br_target = tgt;
    #1;
  endtask

  task automatic advanceClock;
    @(posedge clock);
    #1;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset = 1'b1;
    applyStimulus(NOP, NOP, NOP, 1'b0, 1'b0, 12'h000);
    #1;
    checkOutput("rst_pc", pc, 12'h000);
    checkOutput("rst_valid", {valid_p3, valid_p4, valid_p5}, 3'b000);
    checkOutput("rst_hold_bubble", {hold_p12, bubble_p3}, 2'b00);
    checkOutput("rst_running", running, 1'b0);
    checkOutput("rst_fwd", {fwd_a, fwd_b}, 4'b0000);
    reset = 1'b0;

    advanceClock();
    checkOutput("stop_hold_bubble", {hold_p12, bubble_p3}, 2'b11);
    checkOutput("stop_running", running, 1'b0);

    applyStimulus(NOP, NOP, NOP, 1'b1, 1'b0, 12'h000);
    advanceClock();
    checkOutput("start_running", running, 1'b1);
    checkOutput("start_pc", pc, 12'h000);
    checkOutput("start_hold", hold_p12, 1'b0);
    applyStimulus(NOP, NOP, NOP, 1'b0, 1'b0, 12'h000);
    advanceClock();
    checkOutput("run_pc1", pc, 12'h001);
    checkOutput("run_v3", valid_p3, 1'b1);
    advanceClock();
    checkOutput("run_pc2", pc, 12'h002);
    checkOutput("run_v4", valid_p4, 1'b1);
    advanceClock();
    checkOutput("run_pc3", pc, 12'h003);
    checkOutput("run_v5", valid_p5, 1'b1);

`ifdef PIPE_FWD_EN
    applyStimulus(SUB, ADD, NOP, 1'b0, 1'b0, 12'h000);
    checkOutput("fwd_addsub_nostall", hold_p12, 1'b0);
    advanceClock();
    checkOutput("fwd_addsub_pc", pc, 12'h004);
    applyStimulus(NOP, SUB, ADD, 1'b0, 1'b0, 12'h000);
    checkOutput("fwd_sub_b", fwd_b, 2'd1);
    checkOutput("fwd_sub_a", fwd_a, 2'd0);
    advanceClock();
    applyStimulus(ADD, LD, NOP, 1'b0, 1'b0, 12'h000);
    checkOutput("ld_stall_hold", hold_p12, 1'b1);
    advanceClock();
    applyStimulus(ADD, NOP, LD, 1'b0, 1'b0, 12'h000);
    checkOutput("ld_bubble_v3", valid_p3, 1'b0);
    checkOutput("ld_bubble_pc", pc, 12'h005);
    checkOutput("ld_one_bubble", hold_p12, 1'b0);
    advanceClock();
    applyStimulus(NOP, ADD, NOP, 1'b0, 1'b0, 12'h000);
    checkOutput("ld_add_fwd_a", fwd_a, 2'd2);
    checkOutput("ld_add_fwd_b", fwd_b, 2'd0);
    checkOutput("ld_add_pc", pc, 12'h006);
    exp_pc = 12'h006;
`else
    applyStimulus(SUB, ADD, NOP, 1'b0, 1'b0, 12'h000);
    checkOutput("raw_p3_hold_bubble", {hold_p12, bubble_p3}, 2'b11);
    advanceClock();
    applyStimulus(SUB, NOP, ADD, 1'b0, 1'b0, 12'h000);
    checkOutput("raw_p4_hold", hold_p12, 1'b1);
    checkOutput("raw_b1_v3", valid_p3, 1'b0);
    checkOutput("raw_b1_pc", pc, 12'h003);
    advanceClock();
    applyStimulus(SUB, NOP, NOP, 1'b0, 1'b0, 12'h000);
    checkOutput("raw_release", hold_p12, 1'b0);
    checkOutput("raw_b2_v3", valid_p3, 1'b0);
    checkOutput("raw_b2_pc", pc, 12'h003);
    advanceClock();
    checkOutput("raw_issue_v3", valid_p3, 1'b1);
    checkOutput("raw_issue_pc", pc, 12'h004);
    exp_pc = 12'h004;
`endif

    applyStimulus(NOP, NOP, NOP, 1'b0, 1'b0, 12'h000);
    for (int i = 0; i < 16 && exp_pc != 12'h010; i++) begin
      advanceClock();
      exp_pc = exp_pc + 12'h001;
      checkOutput("count_pc", pc, {20'h0, exp_pc});
    end

    // Branch at 0x010 with a would-be RAW hazard in the same cycle.
    applyStimulus(SUB, BR, ADD, 1'b0, 1'b0, 12'h040);
    checkOutput("br_wins_hold", hold_p12, 1'b0);
    advanceClock();
    checkOutput("br_pc", pc, 12'h040);
    checkOutput("br_squash1", valid_p3, 1'b0);
    applyStimulus(NOP, NOP, NOP, 1'b0, 1'b0, 12'h000);
    advanceClock();
    checkOutput("br_pc_next", pc, 12'h041);
    checkOutput("br_squash2", valid_p3, 1'b0);
    advanceClock();
    checkOutput("br_resume_v3", valid_p3, 1'b1);

    applyStimulus(NOP, BCC, NOP, 1'b0, 1'b0, 12'hFFF);
    advanceClock();
    checkOutput("bcc_not_taken_pc", pc, 12'h043);
    checkOutput("bcc_not_taken_v3", valid_p3, 1'b1);
    applyStimulus(NOP, BCC, NOP, 1'b0, 1'b1, 12'hFFF);
    advanceClock();
    checkOutput("bcc_taken_pc", pc, 12'hFFF);
    applyStimulus(NOP, NOP, NOP, 1'b0, 1'b0, 12'h000);
    advanceClock();
    checkOutput("pc_wrap", pc, 12'h000);
    advanceClock();
    checkOutput("pc_after_wrap", pc, 12'h001);

    applyStimulus(NOP, HLT, NOP, 1'b0, 1'b0, 12'h000);
    advanceClock();
    checkOutput("hlt_running", running, 1'b0);
    checkOutput("hlt_pc", pc, 12'h002);
    checkOutput("hlt_hold", hold_p12, 1'b1);
    applyStimulus(NOP, NOP, NOP, 1'b1, 1'b0, 12'h000);
    advanceClock();
    checkOutput("drain_ignores_exec", running, 1'b0);
    applyStimulus(NOP, NOP, NOP, 1'b0, 1'b0, 12'h000);
    advanceClock();
    checkOutput("drain_v45", {valid_p4, valid_p5}, 2'b01);
    checkOutput("drain_pc_frozen", pc, 12'h002);
    advanceClock();
    checkOutput("drain_empty", {valid_p3, valid_p4, valid_p5}, 3'b000);
    applyStimulus(NOP, NOP, NOP, 1'b1, 1'b0, 12'h000);
    advanceClock();
    checkOutput("drain_last_exec_ignored", running, 1'b0);
    applyStimulus(NOP, NOP, NOP, 1'b0, 1'b0, 12'h000);
    advanceClock();
    applyStimulus(NOP, NOP, NOP, 1'b1, 1'b0, 12'h000);
    advanceClock();
    checkOutput("restart_running", running, 1'b1);
    checkOutput("restart_pc", pc, 12'h002);
    applyStimulus(NOP, NOP, NOP, 1'b0, 1'b0, 12'h000);
    advanceClock();
    advanceClock();
    checkOutput("pre_reset_v34", {valid_p3, valid_p4}, 2'b11);

    reset = 1'b1;
    #1;
    checkOutput("midrun_reset_valid", {valid_p3, valid_p4, valid_p5}, 3'b000);
    checkOutput("midrun_reset_pc", pc, 12'h000);
    checkOutput("midrun_reset_running", running, 1'b0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
